// File: rtl/alu_wb_stage.sv
// Writeback staging for the 8-bit ALU: a 2-entry in-order elastic buffer feeding the
// register-file write port, with architectural flag update and bnez branch pulse on commit.
module alu_wb_stage #(
    parameter int W  = 8,
    parameter int A  = 3,
    parameter int RA = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_rslt,
    input  logic          in_sc,
    input  logic          in_pari,
    input  logic [A:0]    in_cmd,
    input  logic [RA-1:0] in_wr_addr,
    input  logic          in_wr_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [RA-1:0] out_addr,
    output logic          out_we,
    output logic          flag_zero,
    output logic          flag_pari,
    output logic          flag_carry,
    output logic          branch_taken,
    output logic [1:0]    occupancy
);

    localparam logic [A:0] CMD_XOR    = (A+1)'(1);
    localparam logic [A:0] CMD_BNEZ   = (A+1)'(2);
    localparam logic [A:0] CMD_ADD    = (A+1)'(3);
    localparam logic [A:0] CMD_LSHIFT = (A+1)'(4);
    localparam logic [A:0] CMD_RSHIFT = (A+1)'(5);
    localparam logic [A:0] CMD_PARI   = (A+1)'(8);
    localparam logic [A:0] CMD_OR     = (A+1)'(10);
    localparam logic [A:0] CMD_SUB    = (A+1)'(11);

    function automatic logic updates_flags(input logic [A:0] cmd);
        case (cmd)
            CMD_XOR, CMD_ADD, CMD_LSHIFT, CMD_RSHIFT,
            CMD_PARI, CMD_OR, CMD_SUB: updates_flags = 1'b1;
            default:                   updates_flags = 1'b0;
        endcase
    endfunction

    logic [W-1:0]  ent_data [2];
    logic          ent_sc   [2];
    logic          ent_pari [2];
    logic [A:0]    ent_cmd  [2];
    logic [RA-1:0] ent_addr [2];
    logic          ent_we   [2];

    logic [1:0] count;
    logic       head;
    logic       tail;
    logic       push;
    logic       pop;

    logic [W-1:0] head_data;
    logic [A:0]   head_cmd;

    assign in_ready  = !reset && (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count;

    assign head_data = ent_data[head];
    assign head_cmd  = ent_cmd[head];

    // Outputs read as zero when empty so stale entries never leak to the register file.
    assign out_data = out_valid ? head_data : '0;
    assign out_addr = out_valid ? ent_addr[head] : '0;
    assign out_we   = out_valid && ent_we[head] && (head_cmd != CMD_BNEZ);

    // Payload storage carries no reset; visibility is governed entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_data[tail] <= in_rslt;
            ent_sc[tail]   <= in_sc;
            ent_pari[tail] <= in_pari;
            ent_cmd[tail]  <= in_cmd;
            ent_addr[tail] <= in_wr_addr;
            ent_we[tail]   <= in_wr_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count        <= 2'd0;
            head         <= 1'b0;
            tail         <= 1'b0;
            flag_zero    <= 1'b0;
            flag_pari    <= 1'b0;
            flag_carry   <= 1'b0;
            branch_taken <= 1'b0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            branch_taken <= pop && (head_cmd == CMD_BNEZ) && head_data[0];
            if (pop && updates_flags(head_cmd)) begin
                flag_zero  <= (head_data == '0);
                flag_pari  <= ent_pari[head];
                flag_carry <= ent_sc[head];
            end
        end
    end

endmodule
